// File: rtl/verifier_compute_io_seq.sv
// Sequences nInputs through one shared elembank, capturing each bank final_out per input.
// Optional WAIT watchdog: define VERIFIER_IO_SEQ_TIMEOUT_EN.
`ifndef F_NBITS
`define F_NBITS 61
`endif
`ifndef F_Q
`define F_Q 61'h1FFF_FFFF_FFFF_FFFF
`endif

module verifier_compute_io_seq #(
    parameter int nInBits   = 2,
    parameter int nInputs   = 1 << nInBits,
    parameter int tmoCycles = 1024
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                en,
    input  logic                restart,
    input  logic [`F_NBITS-1:0] tau,
    input  logic [`F_NBITS-1:0] bank_out,
    input  logic                bank_ready_pulse,
    output logic                bank_en,
    output logic                bank_restart,
    output logic [nInBits-1:0]  bank_sel,
    output logic [`F_NBITS-1:0] tau_out,
    output logic [`F_NBITS-1:0] m_tau_p1,
    output logic [`F_NBITS-1:0] results [nInputs],
    output logic [nInputs-1:0]  results_valid,
    output logic                err,
    output logic                ready,
    output logic                ready_pulse
);

    if (nInputs != (1 << nInBits)) begin : g_bad_ninputs
        $error("nInputs must equal 1 << nInBits");
    end
    if (tmoCycles < 1 || tmoCycles > 65535) begin : g_bad_tmo
        $error("tmoCycles must fit the 16-bit watchdog counter");
    end

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_KICK, S_WAIT} state_t;

    localparam logic [`F_NBITS-1:0] FQ   = `F_Q;
    localparam logic [`F_NBITS-1:0] ONE  = `F_NBITS'(1);
    localparam logic [nInBits-1:0]  LAST = nInBits'(nInputs - 1);

    state_t                state;
    logic                  ready_dly;
    logic                  cap_now;
    logic [`F_NBITS-1:0]   cap_val;

`ifdef VERIFIER_IO_SEQ_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic        tmo_hit;

    assign tmo_hit = (state == S_WAIT) && !bank_ready_pulse && (tmo_cnt == 16'(tmoCycles - 1));

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            tmo_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (state == S_KICK)
                tmo_cnt <= '0;
            else if (state == S_WAIT)
                tmo_cnt <= tmo_cnt + 16'd1;
            if (tmo_hit && !restart)
                err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

    // A watchdog expiry is treated as a capture of zero so both paths share one advance.
    always_comb begin
        cap_now = (state == S_WAIT) && bank_ready_pulse;
        cap_val = bank_out;
`ifdef VERIFIER_IO_SEQ_TIMEOUT_EN
        if (tmo_hit) begin
            cap_now = 1'b1;
            cap_val = '0;
        end
`endif
    end

    assign ready       = (state == S_IDLE);
    assign ready_pulse = ready & ~ready_dly;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)
            ready_dly <= 1'b1;
        else
            ready_dly <= ready;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state         <= S_IDLE;
            bank_en       <= 1'b0;
            bank_restart  <= 1'b0;
            bank_sel      <= '0;
            tau_out       <= '0;
            m_tau_p1      <= '0;
            results_valid <= '0;
            for (int unsigned i = 0; i < nInputs; i++)
                results[i] <= '0;
        end else if (restart) begin
            state         <= S_LOAD;
            bank_sel      <= '0;
            results_valid <= '0;
            bank_en       <= 1'b0;
            bank_restart  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (en) begin
                    state         <= S_LOAD;
                    bank_sel      <= '0;
                    results_valid <= '0;
                end
                S_LOAD: begin
                    tau_out      <= tau;
                    m_tau_p1     <= (tau <= ONE) ? (ONE - tau) : (FQ - tau + ONE);
                    bank_en      <= 1'b1;
                    bank_restart <= 1'b1;
                    state        <= S_KICK;
                end
                S_KICK: begin
                    bank_restart <= 1'b0;
                    state        <= S_WAIT;
                end
                S_WAIT: if (cap_now) begin
                    results[bank_sel]       <= cap_val;
                    results_valid[bank_sel] <= 1'b1;
                    if (bank_sel == LAST) begin
                        bank_en <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        bank_sel     <= bank_sel + nInBits'(1);
                        bank_restart <= 1'b1;
                        state        <= S_KICK;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_verifier_compute_io_seq.sv
// Randomized bench for verifier_compute_io_seq: reactive elembank stub plus a per-run
// reference model of captured results, (1 - tau) mod q and start-to-ready latency.
`ifndef F_NBITS
`define F_NBITS 61
`endif
`ifndef F_Q
`define F_Q 61'h1FFF_FFFF_FFFF_FFFF
`endif

module tb_verifier_compute_io_seq;

    localparam longint unsigned Q = 64'h1FFF_FFFF_FFFF_FFFF;
    localparam int N = 4;

    logic                clk = 1'b0;
    logic                rstb = 1'b0;
    logic                en = 1'b0;
    logic                restart = 1'b0;
    logic [`F_NBITS-1:0] tau = '0;
    logic [`F_NBITS-1:0] bank_out = '0;
    logic                bank_ready_pulse = 1'b0;
    logic                bank_en, bank_restart;
    logic [1:0]          bank_sel;
    logic [`F_NBITS-1:0] tau_out, m_tau_p1;
    logic [`F_NBITS-1:0] results [N];
    logic [N-1:0]        results_valid;
    logic                err, ready, ready_pulse;

    int n_checks = 0;
    int n_fail   = 0;
    longint unsigned exp_res [N];
    logic [N-1:0]    exp_valid;

    verifier_compute_io_seq #(.nInBits(2), .tmoCycles(1024)) dut (
        .clk(clk), .rstb(rstb), .en(en), .restart(restart), .tau(tau),
        .bank_out(bank_out), .bank_ready_pulse(bank_ready_pulse),
        .bank_en(bank_en), .bank_restart(bank_restart), .bank_sel(bank_sel),
        .tau_out(tau_out), .m_tau_p1(m_tau_p1), .results(results),
        .results_valid(results_valid), .err(err), .ready(ready), .ready_pulse(ready_pulse)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [`F_NBITS-1:0] rand_fe();
        longint unsigned x;
        x = {$urandom, $urandom};
        return `F_NBITS'(x % Q);
    endfunction

    task automatic check_results(input string tag);
        for (int i = 0; i < N; i++)
            check_eq(tag, 64'(results[i]), exp_res[i]);
        check_eq({tag, "_valid"}, 64'(results_valid), 64'(exp_valid));
    endtask

    // One full sequencing run; abort_idx >= 0 fires restart with a coincident bank pulse
    // on the first WAIT cycle of that input, after which the run starts over from LOAD.
    task automatic run(input longint unsigned t, input int abort_idx);
        int d [N];
        logic [`F_NBITS-1:0] v [N];
        int idx, cyc, cnt, exp_cyc;
        bit armed, aborted;
        for (int i = 0; i < N; i++) begin
            d[i] = int'($urandom_range(0, 3));
            v[i] = rand_fe();
        end
        exp_cyc = 1;
        for (int i = 0; i < N; i++) exp_cyc += 2 + d[i];
        tau = `F_NBITS'(t);
        en  = 1'b1;
        @(negedge clk);
        en = 1'b0;
        check_eq("ready_load", 64'(ready), 64'd0);
        exp_valid = '0;
        cyc = 1; idx = 0; armed = 0; aborted = 0; cnt = 0;
        while (!ready && cyc < 200) begin
            bank_ready_pulse = 1'b0;
            restart = 1'b0;
            if (cyc >= 2) tau = rand_fe();
            if (bank_restart) begin
                check_eq("kick_sel", 64'(bank_sel), 64'(idx));
                check_eq("kick_en", 64'(bank_en), 64'd1);
                cnt = d[idx];
                armed = 1;
                if ($urandom_range(0, 1) == 1) begin
                    bank_ready_pulse = 1'b1;
                    bank_out = rand_fe();
                end
            end else if (armed) begin
                if (idx == abort_idx && !aborted) begin
                    restart = 1'b1;
                    bank_ready_pulse = 1'b1;
                    bank_out = rand_fe();
                    tau = `F_NBITS'(t);
                    aborted = 1;
                    @(negedge clk);
                    restart = 1'b0;
                    bank_ready_pulse = 1'b0;
                    check_eq("abort_sel", 64'(bank_sel), 64'd0);
                    check_eq("abort_valid", 64'(results_valid), 64'd0);
                    check_eq("abort_en", 64'(bank_en), 64'd0);
                    check_eq("abort_ready", 64'(ready), 64'd0);
                    check_eq("abort_keep", 64'(results[idx]), exp_res[idx]);
                    exp_valid = '0;
                    idx = 0; armed = 0; cyc = 1;
                    continue;
                end else if (cnt == 0) begin
                    check_eq("wait_en", 64'(bank_en), 64'd1);
                    bank_ready_pulse = 1'b1;
                    bank_out = v[idx];
                    exp_res[idx] = 64'(v[idx]);
                    exp_valid[idx] = 1'b1;
                    idx++;
                    armed = 0;
                end else begin
                    cnt--;
                end
            end else if (cyc == 1 && $urandom_range(0, 1) == 1) begin
                bank_ready_pulse = 1'b1;
                bank_out = rand_fe();
            end
            @(negedge clk);
            cyc++;
        end
        check_eq("done_in_budget", 64'(ready), 64'd1);
        check_eq("latency", 64'(cyc - 1), 64'(exp_cyc));
        check_eq("ready_pulse_hi", 64'(ready_pulse), 64'd1);
        check_eq("m_tau_p1", 64'(m_tau_p1), (Q + 64'd1 - t) % Q);
        check_eq("tau_out", 64'(tau_out), t);
        check_eq("idle_en", 64'(bank_en), 64'd0);
        check_eq("err", 64'(err), 64'd0);
        check_results("res");
        bank_ready_pulse = 1'b1;
        bank_out = rand_fe();
        @(negedge clk);
        bank_ready_pulse = 1'b0;
        check_eq("ready_pulse_lo", 64'(ready_pulse), 64'd0);
        check_results("idle_ignore");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) exp_res[i] = 0;
        exp_valid = '0;
        #12;
        check_eq("rst_ready", 64'(ready), 64'd1);
        check_eq("rst_ready_pulse", 64'(ready_pulse), 64'd0);
        check_eq("rst_bank_en", 64'(bank_en), 64'd0);
        check_eq("rst_m_tau", 64'(m_tau_p1), 64'd0);
        check_results("rst_res");
        @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        check_eq("post_rst_ready_pulse", 64'(ready_pulse), 64'd0);

        run(64'd5, -1);
        run(64'd0, -1);
        run(64'd1, -1);
        run(Q - 64'd1, -1);
        run(64'(rand_fe()), 2);
        for (int k = 0; k < 4; k++) run(64'(rand_fe()), -1);

        // Asynchronous reset in the middle of a WAIT
        tau = `F_NBITS'(7);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        for (int k = 0; k < 20 && !bank_restart; k++) @(negedge clk);
        check_eq("pre_rst_kick", 64'(bank_restart), 64'd1);
        @(negedge clk);
        #2;
        rstb = 1'b0;
        #1;
        for (int i = 0; i < N; i++) exp_res[i] = 0;
        exp_valid = '0;
        check_eq("arst_ready", 64'(ready), 64'd1);
        check_eq("arst_ready_pulse", 64'(ready_pulse), 64'd0);
        check_eq("arst_bank_en", 64'(bank_en), 64'd0);
        check_eq("arst_bank_restart", 64'(bank_restart), 64'd0);
        check_eq("arst_sel", 64'(bank_sel), 64'd0);
        check_eq("arst_tau_out", 64'(tau_out), 64'd0);
        check_eq("arst_m_tau", 64'(m_tau_p1), 64'd0);
        check_eq("arst_err", 64'(err), 64'd0);
        check_results("arst_res");
        @(negedge clk);
        rstb = 1'b1;
        run(64'd2, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/verifier_compute_io_seq.md
VERIFIER_COMPUTE_IO_SEQ -- requirements
Module: verifier_compute_io_seq

Interface
REQ-001 SHALL have parameter nInBits, default 2, meaning log2 of the number of inputs sequenced through one shared elembank.
REQ-002 SHALL have parameter nInputs, default 1<<nInBits, meaning the input count; do-not-override, and a mismatch SHALL be a generate-time error.
REQ-003 SHALL have parameter tmoCycles, default 1024, meaning the watchdog limit in cycles; it is used only when REQ-030 is compiled in.
REQ-004 SHALL have port clk, input, 1 bit, meaning the single clock.
REQ-005 SHALL have port rstb, input, 1 bit, meaning the reset; reset is asynchronous and active-low.
REQ-006 SHALL have port en, input, 1 bit, meaning a start request, sampled only in IDLE.
REQ-007 SHALL have port restart, input, 1 bit, meaning abort and restart from input 0.
REQ-008 SHALL have port tau, input, `F_NBITS, meaning the evaluation point, captured in LOAD.
REQ-009 SHALL have port bank_out, input, `F_NBITS, meaning the elembank final_out.
REQ-010 SHALL have port bank_ready_pulse, input, 1 bit, meaning the elembank completion pulse.
REQ-011 SHALL have port bank_en, output, 1 bit, meaning the elembank enable.
REQ-012 SHALL have port bank_restart, output, 1 bit, meaning the elembank restart.
REQ-013 SHALL have port bank_sel, output, nInBits, meaning the index of the input currently muxed into the bank.
REQ-014 SHALL have port tau_out, output, `F_NBITS, meaning the registered tau driven to the bank.
REQ-015 SHALL have port m_tau_p1, output, `F_NBITS, meaning the registered value (1 - tau) mod `F_Q.
REQ-016 SHALL have port results, output, `F_NBITS x nInputs (unpacked), meaning the per-input bank results.
REQ-017 SHALL have port results_valid, output, nInputs, meaning a per-entry valid bit.
REQ-018 SHALL have port err, output, 1 bit, meaning a sticky timeout flag.
REQ-019 SHALL have ports ready and ready_pulse, output, 1 bit each, meaning idle and the rising edge of ready.

Function
REQ-020 SHALL implement states IDLE, LOAD, KICK and WAIT; ready SHALL be 1 only in IDLE.
REQ-021 IDLE with en=1 SHALL move to LOAD next cycle, with bank_sel=0 and results_valid cleared.
REQ-022 LOAD SHALL register tau_out<=tau and m_tau_p1<=(tau<=1 ? 1-tau : `F_Q+1-tau), then go to KICK; the result SHALL be modulo-correct for tau in [0, `F_Q-1].
REQ-023 KICK SHALL assert bank_restart=1 and bank_en=1 for exactly one cycle, then go to WAIT.
REQ-024 WAIT SHALL hold bank_en=1 and bank_restart=0; bank_ready_pulse SHALL be ignored in every other state.
REQ-025 On bank_ready_pulse in WAIT, the block SHALL set results[bank_sel]<=bank_out and results_valid[bank_sel]<=1 in that same cycle.
REQ-026 After the capture in REQ-025, if bank_sel==nInputs-1 the block SHALL go to IDLE with bank_en<=0; otherwise it SHALL set bank_sel<=bank_sel+1 and go to KICK; bank_sel SHALL NOT wrap.
REQ-027 restart=1 in any state SHALL go to LOAD next cycle, with bank_sel=0, results_valid=0, bank_en=0 and err unchanged; restart SHALL take priority over en and over bank_ready_pulse; results data SHALL be retained until overwritten.
REQ-028 ready_pulse SHALL equal ready & ~ready_dly, where ready_dly is ready registered.
REQ-029 Minimum latency per input SHALL be KICK plus 1 WAIT cycle; a full run with a pulse on the first WAIT cycle SHALL take 1 + 2*nInputs cycles from start to ready.

Configuration
REQ-030 With VERIFIER_IO_SEQ_TIMEOUT_EN defined, a 16-bit counter SHALL clear in KICK and count in WAIT; on reaching tmoCycles, results[bank_sel]<=0, valid<=1, err<=1, and the block SHALL advance per REQ-026.
REQ-031 Without VERIFIER_IO_SEQ_TIMEOUT_EN, WAIT SHALL be unbounded, err SHALL be tied to 0, and no counter SHALL be instantiated.

Reset
REQ-032 With rstb=0, the block SHALL asynchronously set state=IDLE, bank_en=0, bank_restart=0, bank_sel=0, tau_out=0, m_tau_p1=0, results=0, results_valid=0 and err=0.
REQ-033 ready_dly SHALL reset to 1, so ready=1 and ready_pulse=0 out of reset.
REQ-034 Reset during WAIT SHALL abandon the run with no partial capture.

Verification
REQ-035 nInBits=2, tau=5, en pulse, bank pulse 3 cycles into each WAIT -> m_tau_p1=`F_Q-4, bank_sel steps 0..3, each bank_restart is 1 cycle, results_valid=4'hF, ready_pulse fires once.
REQ-036 tau=0, then tau=1, and tau=`F_Q-1 -> m_tau_p1=1, 0 and 2 respectively.
REQ-037 restart asserted in WAIT at bank_sel=2 together with bank_ready_pulse -> no capture, LOAD next cycle, bank_sel=0, results_valid=0.
REQ-038 bank_ready_pulse driven in IDLE and KICK -> ignored, with results unchanged.
REQ-039 With TIMEOUT_EN and tmoCycles=8, the bank is never pulsed -> each input times out after 8 WAIT cycles, results=0, err=1 (sticky), and the run completes.
REQ-040 rstb dropped mid-WAIT -> all outputs take their REQ-032/REQ-033 values immediately, with ready=1 and ready_pulse=0.
